// File: rtl/serial_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_pkg : shared types and helpers for the serial shift-link receivers
// Rev 1.0
// ---------------------------------------------------------------------------
package serial_pkg;

   localparam int SER_WORD_W_DEFAULT = 4;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_e;

   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_collect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sipo_collect : MSB-first bit assembler with frame_sync realignment
// Rev 1.0
// ---------------------------------------------------------------------------
module sipo_collect
   import serial_pkg::*;
#(
   parameter int WIDTH = SER_WORD_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en_i,
   input  logic             data_in_i,
   input  logic             frame_sync_i,
   output logic             word_done_o,
   output logic [WIDTH-1:0] word_o
);

   localparam int             CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  C_ONE  = CW'(1);

   logic [WIDTH-2:0] shreg_q, shreg_d;
   logic [WIDTH-2:0] w_shift;
   logic [CW-1:0]    cnt_q, cnt_d;

   generate
      if (WIDTH == 2) begin : g_shift_w2
         assign w_shift = data_in_i;
      end else begin : g_shift_wn
         assign w_shift = {shreg_q[WIDTH-3:0], data_in_i};
      end
   endgenerate

   // A frame_sync bit is always an MSB, so it can never close a word.
   assign word_done_o = shift_en_i & ~frame_sync_i & (cnt_q == C_LAST);
   assign word_o      = {shreg_q, data_in_i};

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (frame_sync_i) begin
         shreg_d = '0;
         if (shift_en_i) begin
            shreg_d[0] = data_in_i;
            cnt_d      = C_ONE;
         end else begin
            cnt_d      = '0;
         end
      end else if (shift_en_i) begin
         shreg_d = w_shift;
         cnt_d   = word_done_o ? '0 : cnt_q + C_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_word_deser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_word_deser : serial-to-parallel receiver with one-entry output buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_word_deser
   import serial_pkg::*;
#(
   parameter int WIDTH = SER_WORD_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             data_in,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             overrun,
   input  logic             overrun_clr
);

   logic             w_done;
   logic [WIDTH-1:0] w_word;

   buf_state_e       state_q;
   logic [WIDTH-1:0] word_q;
   logic             valid_q;
   logic             ovr_q;

   sipo_collect #(
      .WIDTH (WIDTH)
   ) u_collect (
      .clk          (clk),
      .rst_n        (rst_n),
      .shift_en_i   (shift_en),
      .data_in_i    (data_in),
      .frame_sync_i (frame_sync),
      .word_done_o  (w_done),
      .word_o       (w_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         word_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         // Set has priority over clear so a drop is never lost.
         if (w_done && (state_q == ST_FULL) && !word_ready) begin
            ovr_q <= 1'b1;
         end else if (overrun_clr) begin
            ovr_q <= 1'b0;
         end

         case (state_q)
            ST_EMPTY: begin
               if (w_done) begin
                  word_q  <= w_word;
                  valid_q <= 1'b1;
                  state_q <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (word_ready) begin
                  if (w_done) begin
                     word_q <= w_word;
                  end else begin
                     valid_q <= 1'b0;
                     state_q <= ST_EMPTY;
                  end
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= ST_EMPTY;
            end
         endcase
      end
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign overrun    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_deser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_word_deser : vector table, reset sequences and scoreboard, WIDTH=4
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_word_deser;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         shift_en, data_in, frame_sync, word_ready, overrun_clr;
   logic [W-1:0] word_out;
   logic         word_valid, overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       se, din, fs, rdy, clr;
      logic       ev;
      logic [3:0] ew;
      logic       eo;
   } vec_t;

   vec_t          tbl[$];
   logic [W-1:0]  sb[$];

   serial_word_deser #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .shift_en    (shift_en),
      .data_in     (data_in),
      .frame_sync  (frame_sync),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic se, input logic d, input logic fs,
                        input logic rdy, input logic clr);
      shift_en    = se;
      data_in     = d;
      frame_sync  = fs;
      word_ready  = rdy;
      overrun_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic se, input logic d, input logic fs, input logic rdy,
                      input logic clr, input logic ev, input logic [3:0] ew, input logic eo);
      vec_t v;
      v.se = se; v.din = d; v.fs = fs; v.rdy = rdy; v.clr = clr;
      v.ev = ev; v.ew = ew; v.eo = eo;
      tbl.push_back(v);
   endtask

   initial begin
      int mcnt;
      logic [W-1:0] mbits;
      logic se, d, fs;

      // single word 1011
      add(1,1,0,0,0, 0,4'b0000,0);
      add(1,0,0,0,0, 0,4'b0000,0);
      add(1,1,0,0,0, 0,4'b0000,0);
      add(1,1,0,0,0, 1,4'b1011,0);
      add(0,0,0,1,0, 0,4'b1011,0);
      // back-to-back, always ready: 1100 0110
      add(1,1,0,1,0, 0,4'b1011,0);
      add(1,1,0,1,0, 0,4'b1011,0);
      add(1,0,0,1,0, 0,4'b1011,0);
      add(1,0,0,1,0, 1,4'b1100,0);
      add(1,0,0,1,0, 0,4'b1100,0);
      add(1,1,0,1,0, 0,4'b1100,0);
      add(1,1,0,1,0, 0,4'b1100,0);
      add(1,0,0,1,0, 1,4'b0110,0);
      add(0,0,0,1,0, 0,4'b0110,0);
      // overrun: 1010 0101 with no ready, then clear
      add(1,1,0,0,0, 0,4'b0110,0);
      add(1,0,0,0,0, 0,4'b0110,0);
      add(1,1,0,0,0, 0,4'b0110,0);
      add(1,0,0,0,0, 1,4'b1010,0);
      add(1,0,0,0,0, 1,4'b1010,0);
      add(1,1,0,0,0, 1,4'b1010,0);
      add(1,0,0,0,0, 1,4'b1010,0);
      add(1,1,0,0,0, 1,4'b1010,1);
      add(0,0,0,0,1, 1,4'b1010,0);
      add(0,0,0,1,0, 0,4'b1010,0);
      // realignment: 1,1 then frame_sync with 0,0,1,1
      add(1,1,0,0,0, 0,4'b1010,0);
      add(1,1,0,0,0, 0,4'b1010,0);
      add(1,0,1,0,0, 0,4'b1010,0);
      add(1,0,0,0,0, 0,4'b1010,0);
      add(1,1,0,0,0, 0,4'b1010,0);
      add(1,1,0,0,0, 1,4'b0011,0);
      add(0,0,0,1,0, 0,4'b0011,0);
      // FULL + ready + completion, then overrun set coincident with clear
      add(1,0,0,0,0, 0,4'b0011,0);
      add(1,0,0,0,0, 0,4'b0011,0);
      add(1,0,0,0,0, 0,4'b0011,0);
      add(1,1,0,0,0, 1,4'b0001,0);
      add(1,1,0,0,0, 1,4'b0001,0);
      add(1,0,0,0,0, 1,4'b0001,0);
      add(1,0,0,0,0, 1,4'b0001,0);
      add(1,1,0,1,0, 1,4'b1001,0);
      add(1,0,0,0,0, 1,4'b1001,0);
      add(1,1,0,0,0, 1,4'b1001,0);
      add(1,1,0,0,0, 1,4'b1001,0);
      add(1,1,0,0,1, 1,4'b1001,1);
      add(0,0,0,0,1, 1,4'b1001,0);
      add(0,0,0,1,0, 0,4'b1001,0);

      // reset state
      rst_n = 1'b0;
      shift_en = 0; data_in = 0; frame_sync = 0; word_ready = 0; overrun_clr = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, word_valid}, 0);
      chk("rst_word",  {28'd0, word_out}, 0);
      chk("rst_ovr",   {31'd0, overrun}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         drive(tbl[i].se, tbl[i].din, tbl[i].fs, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("vec%0d_valid", i), {31'd0, word_valid}, {31'd0, tbl[i].ev});
         chk($sformatf("vec%0d_word", i),  {28'd0, word_out},   {28'd0, tbl[i].ew});
         chk($sformatf("vec%0d_ovr", i),   {31'd0, overrun},    {31'd0, tbl[i].eo});
      end

      // reset mid-word, then gapped bits 1,1,1,0
      drive(1,1,0,0,0);
      drive(1,0,0,0,0);
      #2 rst_n = 1'b0;
      #2;
      chk("midrst_word",  {28'd0, word_out}, 0);
      chk("midrst_valid", {31'd0, word_valid}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1,1,0,0,0);
      drive(0,0,0,0,0);
      drive(1,1,0,0,0);
      drive(0,1,0,0,0);
      drive(1,1,0,0,0);
      drive(0,0,0,0,0);
      chk("gap_pending_valid", {31'd0, word_valid}, 0);
      drive(1,0,0,0,0);
      chk("gap_valid", {31'd0, word_valid}, 1);
      chk("gap_word",  {28'd0, word_out}, {28'd0, 4'b1110});
      drive(0,0,0,1,0);
      chk("gap_drain", {31'd0, word_valid}, 0);

      // random gapped stream with occasional realignment, consumer always ready
      mcnt  = 0;
      mbits = '0;
      for (int n = 0; n < 400; n++) begin
         se = ($urandom_range(0, 3) != 0);
         d  = 1'($urandom_range(0, 1));
         fs = ($urandom_range(0, 19) == 0);
         if (fs) begin
            mcnt  = se ? 1 : 0;
            mbits = {3'b000, d};
         end else if (se) begin
            mbits = {mbits[W-2:0], d};
            mcnt++;
            if (mcnt == W) begin
               sb.push_back(mbits);
               mcnt = 0;
            end
         end
         drive(se, d, fs, 1, 0);
         if (word_valid) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_word", 1, 0);
            end else begin
               chk("sb_word", {28'd0, word_out}, {28'd0, sb.pop_front()});
            end
         end
         if (overrun) chk("sb_ovr", {31'd0, overrun}, 0);
      end
      chk("sb_drain", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
